// File: rtl/if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit
//
// Instruction-fetch stage with a prefetch queue. Owns the program counter,
// issues sequential word fetches to a synchronous one-cycle instruction
// memory, buffers returned words in a DEPTH-entry FIFO and hands them to
// decode. Redirects from EXE (taken branch, higher priority) and ID (jump)
// flush the queue, drop any in-flight fetch and restart at the target.
//
// Optional feature macro: IF_PREFETCH_BYPASS_EN
//   When defined, a response arriving while the queue is empty and decode
//   is ready goes straight to dec_* without being queued.
//
// Parameters:
//   XLEN      address / instruction width
//   DEPTH     prefetch queue entries (power of 2, >= 2)
//   RESET_PC  PC loaded by reset (word aligned)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (= pc)
//   imem_rdata          instruction word, valid the cycle after imem_req
//   dec_valid/dec_ready decode handshake; a word transfers in any cycle
//                       where both are high. dec_valid never depends on
//                       dec_ready except in the bypass case.
//   dec_instr           head instruction
//   dec_pc_plus4        head PC + 4
//   ex_redirect_*       taken branch from EXE
//   id_redirect_*       jump from ID
//   q_count             entries currently in the queue
// ---------------------------------------------------------------------------
module if_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [XLEN-1:0]            dec_instr,
    output logic [XLEN-1:0]            dec_pc_plus4,
    input  logic                       ex_redirect_valid,
    input  logic [XLEN-1:0]            ex_redirect_pc,
    input  logic                       id_redirect_valid,
    input  logic [XLEN-1:0]            id_redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  instr_mem_q [DEPTH];
    logic [XLEN-1:0]  instr_mem_d [DEPTH];
    logic [XLEN-1:0]  pc4_mem_q   [DEPTH];
    logic [XLEN-1:0]  pc4_mem_d   [DEPTH];

    logic             redirect_any;
    logic [XLEN-1:0]  redirect_sel;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W:0]   occupancy;
    logic             bypass_hit;
    logic             push;
    logic             pop;

    always_comb begin
        redirect_any = ex_redirect_valid || id_redirect_valid;
        redirect_sel = ex_redirect_valid ? ex_redirect_pc : id_redirect_pc;
        redirect_pc  = redirect_sel & ~XLEN'(3);

        // Slots already promised to the queue: stored words plus the one
        // coming back from memory. A pop this cycle is not credited, which
        // keeps imem_req off the dec_ready path.
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        imem_req  = rst_n && !redirect_any && (occupancy < DEPTH_C);
        imem_addr = pc_q;

`ifdef IF_PREFETCH_BYPASS_EN
        bypass_hit = (count_q == '0) && inflight_q && dec_ready && !redirect_any;
`else
        bypass_hit = 1'b0;
`endif

        push      = inflight_q && !redirect_any && !bypass_hit;
        pop       = (count_q != '0) && !redirect_any && dec_ready;
        dec_valid = ((count_q != '0) && !redirect_any) || bypass_hit;

`ifdef IF_PREFETCH_BYPASS_EN
        dec_instr    = bypass_hit ? imem_rdata : instr_mem_q[rd_ptr_q];
        dec_pc_plus4 = bypass_hit ? pc_q : pc4_mem_q[rd_ptr_q];
`else
        dec_instr    = instr_mem_q[rd_ptr_q];
        dec_pc_plus4 = pc4_mem_q[rd_ptr_q];
`endif
        q_count = count_q;

        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        inflight_d  = 1'b0;
        instr_mem_d = instr_mem_q;
        pc4_mem_d   = pc4_mem_q;

        if (redirect_any) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (imem_req) begin
                pc_d = pc_q + XLEN'(4);
            end
            inflight_d = imem_req;
            // pc only moves on a request or a redirect, and a redirect kills
            // the in-flight fetch, so pc_q is the returning word's PC + 4.
            if (push) begin
                instr_mem_d[wr_ptr_q] = imem_rdata;
                pc4_mem_d[wr_ptr_q]   = pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc4_mem_q[i]   <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            instr_mem_q <= instr_mem_d;
            pc4_mem_q   <= pc4_mem_d;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_unit
//
// Directed bench for if_prefetch_unit with RESET_PC = 500 and DEPTH = 4.
// A small instruction memory returns addr ^ 0xA5A50000 one cycle after each
// request. Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_if_prefetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef IF_PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic            clk;
    logic            rst_n;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc_plus4;
    logic            ex_redirect_valid;
    logic [XLEN-1:0] ex_redirect_pc;
    logic            id_redirect_valid;
    logic [XLEN-1:0] id_redirect_pc;
    logic [2:0]      q_count;

    int n_total;
    int n_bad;

    if_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'd500)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .dec_valid         (dec_valid),
        .dec_ready         (dec_ready),
        .dec_instr         (dec_instr),
        .dec_pc_plus4      (dec_pc_plus4),
        .ex_redirect_valid (ex_redirect_valid),
        .ex_redirect_pc    (ex_redirect_pc),
        .id_redirect_valid (id_redirect_valid),
        .id_redirect_pc    (id_redirect_pc),
        .q_count           (q_count)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // instruction memory model
    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    initial imem_rdata = '0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [XLEN-1:0] got,
                         input logic [XLEN-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called in the first cycle a fetch to target t is requested, with
    // dec_ready high; checks n consecutive cycles of streaming.
    task automatic run_stream(input logic [XLEN-1:0] t, input int n);
        logic [XLEN-1:0] a;
        for (int c = 1; c <= n; c++) begin
            a = t + 32'(4 * (c - 1));
            check("stream_req", {31'd0, imem_req}, 32'd1);
            check("stream_addr", imem_addr, a);
            check("stream_valid", {31'd0, dec_valid}, {31'd0, c >= 1 + LAT});
            if (c >= 1 + LAT) begin
                check("stream_pc4", dec_pc_plus4, t + 32'(4 * (c - LAT)));
                check("stream_instr", dec_instr,
                      mem_word(t + 32'(4 * (c - LAT - 1))));
            end
            step();
        end
    endtask

    task automatic redirect(input logic ex_v, input logic [XLEN-1:0] ex_pc,
                            input logic id_v, input logic [XLEN-1:0] id_pc,
                            input logic [XLEN-1:0] target);
        ex_redirect_valid = ex_v;
        ex_redirect_pc    = ex_pc;
        id_redirect_valid = id_v;
        id_redirect_pc    = id_pc;
        #1;
        check("redir_valid_low", {31'd0, dec_valid}, 32'd0);
        check("redir_req_low", {31'd0, imem_req}, 32'd0);
        step();
        ex_redirect_valid = 1'b0;
        id_redirect_valid = 1'b0;
        #1;
        check("redir_qcount", {29'd0, q_count}, 32'd0);
        run_stream(target, 4);
    endtask

    initial begin
        int nreq;
        n_total = 0;
        n_bad   = 0;
        rst_n             = 1'b0;
        dec_ready         = 1'b1;
        ex_redirect_valid = 1'b0;
        ex_redirect_pc    = '0;
        id_redirect_valid = 1'b0;
        id_redirect_pc    = '0;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_qcount", {29'd0, q_count}, 32'd0);
        check("rst_instr", dec_instr, 32'd0);
        check("rst_pc4", dec_pc_plus4, 32'd0);

        // sequential fetch from RESET_PC
        rst_n = 1'b1;
        #1;
        run_stream(32'd500, 6);

        // stall: queue fills, fetch stops
        rst_n     = 1'b0;
        dec_ready = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
        #1;
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) begin
                check("stall_addr", imem_addr, 32'(500 + 4 * nreq));
                nreq++;
            end
            step();
        end
        check("stall_nreq", 32'(nreq), 32'd4);
        check("stall_qcount", {29'd0, q_count}, 32'd4);
        check("stall_req_off", {31'd0, imem_req}, 32'd0);
        check("stall_valid", {31'd0, dec_valid}, 32'd1);

        // release: in-order pops, fetch resumes at 516
        dec_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            check("drain_valid", {31'd0, dec_valid}, 32'd1);
            check("drain_pc4", dec_pc_plus4, 32'(504 + 4 * j));
            check("drain_instr", dec_instr, mem_word(32'(500 + 4 * j)));
            check("drain_req", {31'd0, imem_req}, {31'd0, j >= 1});
            if (j >= 1) check("drain_addr", imem_addr, 32'(516 + 4 * (j - 1)));
            step();
        end

        // simultaneous EXE and ID redirect: EXE wins
        redirect(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 32'h0000_0100);
        // misaligned jump target
        redirect(1'b0, 32'h0, 1'b1, 32'h0000_0203, 32'h0000_0200);
        // address wrap
        redirect(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'hFFFF_FFF8);

        // reset mid-stream with a full queue
        dec_ready = 1'b0;
        #1;
        repeat (8) step();
        check("full_qcount", {29'd0, q_count}, 32'd4);
        check("full_valid", {31'd0, dec_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, dec_valid}, 32'd0);
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_qcount", {29'd0, q_count}, 32'd0);
        step();
        rst_n     = 1'b1;
        dec_ready = 1'b1;
        #1;
        run_stream(32'd500, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
